// File: rtl/h264_invtransform_stream.sv
// rtl/h264_invtransform_stream.sv - streaming H.264 4x4 inverse transform with double-buffered blocks
// Define H264_INVTRANSFORM_CLIP_EN to saturate residuals instead of truncating them.
module h264_invtransform_stream #(
  parameter int IN_W  = 16,
  parameter int INT_W = 18,
  parameter int OUT_W = 10,
  parameter int SHIFT = 6
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic signed [IN_W-1:0]  WIN,
  output logic                    IN_READY,
  output logic                    VALID,
  input  logic                    OUT_READY,
  output logic [4*OUT_W-1:0]      XOUT
);

  typedef enum logic [2:0] {P_IDLE, P_ROW, P_COL, P_RND, P_DONE} phase_t;

  localparam logic signed [INT_W-1:0] ROUND = INT_W'(1 << (SHIFT - 1));
  localparam logic signed [INT_W-1:0] MAXV  = INT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [INT_W-1:0] MINV  = -MAXV - INT_W'(1);

  phase_t                  phase;
  logic signed [INT_W-1:0] coll  [16];
  logic signed [INT_W-1:0] blk   [16];
  logic signed [INT_W-1:0] row_f [16];
  logic signed [INT_W-1:0] col_h [16];
  logic signed [INT_W-1:0] rnd_x [16];
  logic [4*OUT_W-1:0]      res_row [4];
  logic [4*OUT_W-1:0]      out_row [4];
  logic [4*INT_W-1:0]      rtmp, ctmp;
  logic signed [INT_W-1:0] rsum, rshr;
  logic [3:0]              idx;
  logic [1:0]              out_idx;
  logic                    full, res_v;
  logic                    accept, res_move, busy, transfer, full_next, res_v_next, busy_next;

  // Matrix slot (row*4+col) of each coefficient in reverse zigzag arrival order.
  function automatic logic [3:0] zz_pos(input logic [3:0] i);
    case (i)
      4'd0:  return 4'd15;  4'd1:  return 4'd14;  4'd2:  return 4'd11;  4'd3:  return 4'd7;
      4'd4:  return 4'd10;  4'd5:  return 4'd13;  4'd6:  return 4'd12;  4'd7:  return 4'd9;
      4'd8:  return 4'd6;   4'd9:  return 4'd3;   4'd10: return 4'd2;   4'd11: return 4'd5;
      4'd12: return 4'd8;   4'd13: return 4'd4;   4'd14: return 4'd1;   default: return 4'd0;
    endcase
  endfunction

  function automatic logic [4*INT_W-1:0] bfly(input logic signed [INT_W-1:0] a0, a1, a2, a3);
    logic signed [INT_W-1:0] e0, e1, e2, e3;
    e0 = a0 + a2;
    e1 = a0 - a2;
    e2 = (a1 >>> 1) - a3;
    e3 = a1 + (a3 >>> 1);
    return {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
  endfunction

  always_comb begin
    rtmp = '0;
    ctmp = '0;
    rsum = '0;
    rshr = '0;
    for (int r = 0; r < 4; r++) begin
      rtmp = bfly(blk[4*r], blk[4*r+1], blk[4*r+2], blk[4*r+3]);
      for (int c = 0; c < 4; c++) row_f[4*r+c] = rtmp[c*INT_W +: INT_W];
    end
    for (int c = 0; c < 4; c++) begin
      ctmp = bfly(blk[c], blk[4+c], blk[8+c], blk[12+c]);
      for (int r = 0; r < 4; r++) col_h[4*r+c] = ctmp[r*INT_W +: INT_W];
    end
    for (int i = 0; i < 16; i++) begin
      rsum = blk[i] + ROUND;
      rshr = rsum >>> SHIFT;
`ifdef H264_INVTRANSFORM_CLIP_EN
      rnd_x[i] = (rshr > MAXV) ? MAXV : ((rshr < MINV) ? MINV : rshr);
`else
      rnd_x[i] = rshr;
`endif
    end
  end

  // Only one block is ever in flight between the collection buffer and the result bank.
  assign accept     = ENABLE && IN_READY;
  assign res_move   = res_v && (!VALID || (OUT_READY && out_idx == 2'd3));
  assign busy       = (phase != P_IDLE) || res_v;
  assign transfer   = full && (!busy || res_move);
  assign full_next  = transfer ? 1'b0 : ((accept && idx == 4'd15) ? 1'b1 : full);
  assign res_v_next = (phase == P_DONE) || (res_v && !res_move);
  assign busy_next  = transfer || (phase inside {P_ROW, P_COL, P_RND}) || res_v_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx      <= '0;
      full     <= 1'b0;
      IN_READY <= 1'b1;
      phase    <= P_IDLE;
      res_v    <= 1'b0;
    end else begin
      if (accept) idx <= idx + 4'd1;
      full     <= full_next;
      IN_READY <= !(full_next && busy_next);
      res_v    <= res_v_next;
      case (phase)
        P_IDLE:  if (transfer) phase <= P_ROW;
        P_ROW:   phase <= P_COL;
        P_COL:   phase <= P_RND;
        P_RND:   phase <= P_DONE;
        default: phase <= P_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) coll[zz_pos(idx)] <= INT_W'(WIN);
    case (phase)
      P_IDLE: if (transfer) blk <= coll;
      P_ROW:  blk <= row_f;
      P_COL:  blk <= col_h;
      P_RND:  blk <= rnd_x;
      default: begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            res_row[r][c*OUT_W +: OUT_W] <= blk[4*r+c][OUT_W-1:0];
      end
    endcase
    if (res_move) out_row <= res_row;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VALID   <= 1'b0;
      out_idx <= '0;
      XOUT    <= '0;
    end else if (res_move) begin
      VALID   <= 1'b1;
      out_idx <= '0;
      XOUT    <= res_row[0];
    end else if (VALID && OUT_READY) begin
      if (out_idx == 2'd3) begin
        VALID <= 1'b0;
      end else begin
        out_idx <= out_idx + 2'd1;
        XOUT    <= out_row[out_idx + 2'd1];
      end
    end
  end

endmodule

// File: tb/tb_h264_invtransform_stream.sv
// tb/tb_h264_invtransform_stream.sv - scoreboard bench for h264_invtransform_stream
module tb_h264_invtransform_stream;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               ENABLE = 1'b0;
  logic signed [15:0] WIN = '0;
  logic               IN_READY;
  logic               VALID;
  logic               OUT_READY = 1'b1;
  logic [39:0]        XOUT;

  h264_invtransform_stream dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .WIN(WIN), .IN_READY(IN_READY),
    .VALID(VALID), .OUT_READY(OUT_READY), .XOUT(XOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int hs_row = 0;
  int stall = 0;
  int t15 = 0;
  bit rand_ordy = 0;
  int coef [16];
  int ord_r [16] = '{3,3,2,1,2,3,3,2,1,0,0,1,2,1,0,0};
  int ord_c [16] = '{3,2,3,3,2,1,0,1,2,3,2,1,0,0,1,0};
  logic [39:0] sb [$];
  int row0_t [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wr(input int v);
    logic [17:0] t;
    t = v[17:0];
    return t[17] ? int'(t) - 262144 : int'(t);
  endfunction

  task automatic bf(input int a0, a1, a2, a3, output int y0, y1, y2, y3);
    int e0, e1, e2, e3;
    e0 = wr(a0 + a2);
    e1 = wr(a0 - a2);
    e2 = wr((a1 >>> 1) - a3);
    e3 = wr(a1 + (a3 >>> 1));
    y0 = wr(e0 + e3); y1 = wr(e1 + e2); y2 = wr(e1 - e2); y3 = wr(e0 - e3);
  endtask

  // Reference: place coefficients, 2-D transform, round, shift, then truncate or saturate.
  task automatic push_block();
    int d [4][4];
    int f [4][4];
    int h [4][4];
    int x;
    logic [31:0] xb;
    logic [39:0] rw;
    for (int i = 0; i < 16; i++) d[ord_r[i]][ord_c[i]] = coef[i];
    for (int r = 0; r < 4; r++) bf(d[r][0], d[r][1], d[r][2], d[r][3], f[r][0], f[r][1], f[r][2], f[r][3]);
    for (int c = 0; c < 4; c++) bf(f[0][c], f[1][c], f[2][c], f[3][c], h[0][c], h[1][c], h[2][c], h[3][c]);
    for (int r = 0; r < 4; r++) begin
      rw = '0;
      for (int c = 0; c < 4; c++) begin
        x = wr(h[r][c] + 32) >>> 6;
`ifdef H264_INVTRANSFORM_CLIP_EN
        if (x > 511) x = 511;
        if (x < -512) x = -512;
`endif
        xb = x;
        rw[c*10 +: 10] = xb[9:0];
      end
      sb.push_back(rw);
    end
  endtask

  function automatic int rnd_coef();
    case ($urandom_range(0, 3))
      0: return 0;
      3: return int'($urandom_range(0, 65535)) - 32768;
      default: return int'($urandom_range(0, 1023)) - 512;
    endcase
  endfunction

  task automatic put(input int v);
    int t = 0;
    ENABLE = 1'b1;
    WIN = 16'(v);
    while (!IN_READY && t < 1000) begin @(posedge CLK); #1; t++; stall++; end
    if (!IN_READY) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: IN_READY=%0b required 1", IN_READY);
    end
    @(posedge CLK); #1;
    ENABLE = 1'b0;
  endtask

  task automatic put_block(input int gap_max);
    int g;
    for (int i = 0; i < 16; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin @(posedge CLK); #1; end
      put(coef[i]);
    end
    t15 = cyc;
    push_block();
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin @(posedge CLK); #1; t++; end
    check("drain_empty", sb.size(), 0);
    repeat (4) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!VALID && t < 60) begin @(negedge CLK); t++; end
  endtask

  task automatic do_reset();
    @(posedge CLK); #3;
    RESET = 1'b1;
    ENABLE = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    check("rst_valid", VALID, 0);
    check("rst_xout", XOUT, 0);
    check("rst_in_ready", IN_READY, 1);
    sb.delete();
    hs_row = 0;
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic dc_block(input string nm, input int v, input logic [39:0] exp_row);
    for (int i = 0; i < 16; i++) coef[i] = 0;
    coef[15] = v;
    vcount = 0;
    put_block(0);
    wait_valid();
    check({nm, "_latency"}, cyc - t15, 6);
    check({nm, "_pixels"}, XOUT, exp_row);
    drain();
    check({nm, "_valid_cycles"}, vcount, 4);
  endtask

  always @(negedge CLK) begin
    if (!RESET && VALID) begin
      vcount++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_row: XOUT=%h with no row expected", XOUT);
      end else begin
        if (XOUT !== sb[0]) begin
          fails++;
          $display("FAIL row_value: XOUT=%h expected %h", XOUT, sb[0]);
        end
        if (OUT_READY) begin
          void'(sb.pop_front());
          if (hs_row == 0) row0_t.push_back(cyc);
          hs_row = (hs_row + 1) % 4;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d rows pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] exp_b1;
    logic [39:0] ovf_row;
    int first_t15;
`ifdef H264_INVTRANSFORM_CLIP_EN
    ovf_row = {4{10'h1FF}};
`else
    ovf_row = {4{10'h200}};
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("reset_valid", VALID, 0);
    check("reset_xout", XOUT, 0);
    check("reset_in_ready", IN_READY, 1);
    RESET = 1'b0;
    @(posedge CLK); #1;

    dc_block("dc640", 640, {4{10'h00A}});
    dc_block("dc_neg64", -64, {4{10'h3FF}});
    dc_block("dc31", 31, {4{10'h000}});

    // Three blocks with ENABLE held high for 48 cycles.
    stall = 0;
    row0_t.delete();
    first_t15 = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) coef[i] = rnd_coef();
      put_block(0);
      if (b == 0) first_t15 = t15;
    end
    drain();
    check("b2b_no_stall", stall, 0);
    check("b2b_row0_count", row0_t.size(), 3);
    if (row0_t.size() == 3) begin
      check("b2b_first_latency", row0_t[0] - first_t15, 6);
      check("b2b_spacing_1", row0_t[1] - row0_t[0], 16);
      check("b2b_spacing_2", row0_t[2] - row0_t[1], 16);
    end

    // Backpressure: block 1 held on the output while blocks 2 and 3 arrive.
    OUT_READY = 1'b0;
    for (int i = 0; i < 16; i++) coef[i] = rnd_coef();
    put_block(2);
    exp_b1 = sb[0];
    wait_valid();
    @(posedge CLK); #1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) coef[i] = rnd_coef();
      put_block(2);
    end
    check("bp_in_ready_low", IN_READY, 0);
    check("bp_valid_held", VALID, 1);
    check("bp_xout_held", XOUT, exp_b1);
    repeat (5) begin @(posedge CLK); #1; end
    check("bp_in_ready_still_low", IN_READY, 0);
    check("bp_xout_still_held", XOUT, exp_b1);
    OUT_READY = 1'b1;
    drain();
    check("bp_in_ready_back", IN_READY, 1);

    // Reset part way through a block, then one clean DC block.
    for (int i = 0; i < 9; i++) put(rnd_coef());
    do_reset();
    dc_block("post_reset_dc640", 640, {4{10'h00A}});

    dc_block("overflow", 32767, ovf_row);

    // Random blocks, random gaps, random output backpressure.
    rand_ordy = 1;
    fork
      begin
        while (rand_ordy) begin
          @(posedge CLK); #1;
          if (rand_ordy) OUT_READY = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 16; i++) coef[i] = rnd_coef();
      put_block(3);
    end
    rand_ordy = 0;
    @(posedge CLK); #2;
    OUT_READY = 1'b1;
    drain();
    check("final_queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
